ring_osc_freq_meter: RTL

// - Clocked measurement controller directly downstream of the inverter-chain counter.
// - Drives the chain's enable/reset, opens a fixed gate window of clk cycles, waits
//   for the chain to stop, then samples the async 24-bit count into the clk domain.
// - Result = oscillator edges per window; offered on a valid/ready handshake.

---
 rtl/ring_osc_meter_pkg.sv | 15 +
 rtl/sync_2ff.sv | 31 +++
 rtl/ring_osc_freq_meter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ring_osc_meter_pkg.sv
// Shared types and defaults for the ring-oscillator frequency meter.
package ring_osc_meter_pkg;

  localparam int unsigned CNT_W_DEFAULT = 24;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StSettle,
    StSample,
    StDone
  } meter_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop bus synchronizer; only safe because the source bus is quiescent when read.
module sync_2ff #(
  parameter int unsigned Width = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q, meta_d;
  logic [Width-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ring_osc_freq_meter.sv
// Gates an external ring-oscillator counter for a fixed clk window and returns the
// synchronized edge count on a valid/ready handshake.
module ring_osc_freq_meter
  import ring_osc_meter_pkg::*;
#(
  parameter int unsigned CNT_W         = CNT_W_DEFAULT,
  parameter int unsigned WINDOW_CYCLES = 1024,
  parameter int unsigned CLEAR_CYCLES  = 4,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned MAX_RETRY     = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             osc_enable,
  output logic             osc_reset,
  input  logic [CNT_W-1:0] osc_count,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             unstable
);

  localparam int unsigned MaxWc    = (WINDOW_CYCLES > CLEAR_CYCLES) ? WINDOW_CYCLES : CLEAR_CYCLES;
  localparam int unsigned MaxPhase = (MaxWc > SETTLE_CYCLES) ? MaxWc : SETTLE_CYCLES;
  localparam int unsigned PhW      = $clog2(MaxPhase + 1);
  localparam int unsigned RetryW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  meter_state_e      state_q, state_d;
  logic [PhW-1:0]    cnt_q, cnt_d;
  logic [1:0]        step_q, step_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [CNT_W-1:0]  prev_q, prev_d;
  logic [CNT_W-1:0]  result_q, result_d;
  logic              unstable_q, unstable_d;
  logic              result_valid_q, result_valid_d;
  logic              busy_q, busy_d;
  logic              osc_enable_q, osc_enable_d;
  logic              osc_reset_q, osc_reset_d;
  logic [CNT_W-1:0]  sync_count;

  sync_2ff #(
    .Width(CNT_W)
  ) u_sync (
    .clk_i(clk),
    .rst_i(reset),
    .d_i  (osc_count),
    .q_o  (sync_count)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    step_d     = step_q;
    retry_d    = retry_q;
    prev_d     = prev_q;
    result_d   = result_q;
    unstable_d = unstable_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        if (cnt_q == PhW'(CLEAR_CYCLES - 1)) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PhW'(1);
        end
      end
      StRun: begin
        if (cnt_q == PhW'(WINDOW_CYCLES - 1)) begin
          state_d = StSettle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PhW'(1);
        end
      end
      StSettle: begin
        if (cnt_q == PhW'(SETTLE_CYCLES - 1)) begin
          state_d = StSample;
          step_d  = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + PhW'(1);
        end
      end
      StSample: begin
        prev_d = sync_count;
        // First steps flush the synchronizer past the lagged enable fall.
        if (step_q != 2'd3) begin
          step_d = step_q + 2'd1;
        end else if (sync_count == prev_q) begin
          result_d   = sync_count;
          unstable_d = 1'b0;
          state_d    = StDone;
        end else if (retry_q == RetryW'(MAX_RETRY - 1)) begin
          result_d   = sync_count;
          unstable_d = 1'b1;
          state_d    = StDone;
        end else begin
          retry_d = retry_q + RetryW'(1);
        end
      end
      StDone: begin
        if (result_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d         = (state_d != StIdle);
    result_valid_d = (state_d == StDone);
    // Chain controls follow the state by one cycle, so reset and enable never overlap.
    osc_reset_d    = (state_q == StClear);
    osc_enable_d   = (state_q == StRun);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      step_q         <= '0;
      retry_q        <= '0;
      prev_q         <= '0;
      result_q       <= '0;
      unstable_q     <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      osc_enable_q   <= 1'b0;
      osc_reset_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      step_q         <= step_d;
      retry_q        <= retry_d;
      prev_q         <= prev_d;
      result_q       <= result_d;
      unstable_q     <= unstable_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      osc_enable_q   <= osc_enable_d;
      osc_reset_q    <= osc_reset_d;
    end
  end

  assign busy         = busy_q;
  assign osc_enable   = osc_enable_q;
  assign osc_reset    = osc_reset_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign unstable     = unstable_q;

endmodule
